montacarga_ctrl: RTL and testbench
==================================

# montacarga_ctrl

Freight-elevator (montacarga) motion controller. It sits directly downstream of the 3-digit combination lock and consumes its `enable_mc` output. It latches floor calls, moves the car one floor per timed travel segment, and opens the door at each requested floor. While `enable_mc` is low it accepts no new work and parks the car.

## Interface
- `N_FLOORS`, 4: number of floors, numbered 0..N_FLOORS-1.
- `FLOOR_W`, 2: width of the floor index; must satisfy 2^FLOOR_W ≥ N_FLOORS.
- `TRAVEL_CYCLES`, 50_000_000: clock cycles to travel one floor.
- `DOOR_CYCLES`, 100_000_000: clock cycles the door stays open.
- `CNT_W`, 27: timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES).
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `enable_mc`  in  1  unlock from the combination lock; 1 = elevator authorised.
- `call_btn`  in  N_FLOORS  floor call buttons, one bit per floor, level-sensitive, already synchronised.
- `motor_up`  out  1  car moving up.
- `motor_down`  out  1  car moving down.
- `door_open`  out  1  door open.
- `floor`  out  FLOOR_W  current floor index.
- `pending`  out  N_FLOORS  latched call requests; drives the call LEDs.
- `out_led_states`  out  4  one-hot state LEDs: 1000 IDLE, 0100 UP, 0010 DOWN, 0001 DOOR.

## Operation
- States:
  - IDLE: stopped, door closed.
  - UP: travelling up.
  - DOWN: travelling down.
  - DOOR: stopped, door open.
- `dir_last` is a 1-bit register recording the direction of the last move; it resets to up.
- Call latching:
  - `pending[i]` is set when `call_btn[i]` = 1 and `enable_mc` = 1.
  - Exception: a call for the current floor while in DOOR is not latched. It reloads the door timer instead.
  - All of `pending` is cleared in any cycle where `enable_mc` = 0.
- IDLE transitions, in priority order:
  1. `pending[floor]` set → DOOR. Clear `pending[floor]` and load the door timer.
  2. Calls exist above and below the car → go in the `dir_last` direction.
  3. Calls exist only above → UP.
  4. Calls exist only below → DOWN.
  5. No calls → stay in IDLE.
  - Entering UP or DOWN loads the travel timer.
- UP and DOWN:
  - When the timer expires, `floor` steps by ±1 and `dir_last` is updated.
  - If the new floor is pending → DOOR, clear that bit, load the door timer.
  - Else if calls remain further in the same direction → reload the timer and continue.
  - Else → IDLE.
- Movement never runs outside 0..N_FLOORS-1. UP is never entered at the top floor, nor DOWN at floor 0. If such an entry occurs, the block goes to IDLE.
- Lock dropped mid-operation (`enable_mc` falls during UP or DOWN):
  - The current segment completes and the car arrives at the next floor.
  - Because `pending` is already cleared, the car goes to IDLE and stays there.
- `enable_mc` falling during DOOR: the door cycle completes, then IDLE.
- Simultaneous set and clear on the same bit: the clear wins only for the arrival/door floor. All other sets take effect.
- Width rule: `floor` arithmetic is unsigned and never wraps.

## Timing
- All outputs are registered Moore outputs decoded from the state register; none depend combinationally on inputs.
- Reset values: state IDLE, `floor` = 0, `pending` = 0, `dir_last` = up, timer = 0, `motor_up` = 0, `motor_down` = 0, `door_open` = 0, `out_led_states` = 1000.
- A call is visible on `pending` 1 cycle after the button is sampled.
- Departure: IDLE → UP/DOWN occurs 1 cycle after `pending` shows the call; the motor output asserts in the same cycle as the state change.
- Travel: exactly TRAVEL_CYCLES cycles in UP/DOWN per floor; `floor` updates on the expiry edge.
- Door: `door_open` is high for exactly DOOR_CYCLES cycles, extended by each reload. IDLE follows on the next edge.
- `motor_up` and `motor_down` are never high together. Neither is ever high while `door_open` = 1.

## Structure
- Shared header `montacarga_defs.vh` holds:
  - state encodings (IDLE, UP, DOWN, DOOR, 2 bits);
  - the LED patterns;
  - the default `N_FLOORS`.
- Sub-module `timer_carga`: loadable down-counter with ports `load`, `load_val[CNT_W-1:0]`, and a `done` pulse. It is instantiated once and shared between the travel and door timing.

## Test plan
Run with `TRAVEL_CYCLES` = 4, `DOOR_CYCLES` = 3, `N_FLOORS` = 4.
- **Locked:** `enable_mc` = 0, pulse `call_btn` = 0100 → `pending` stays 0000, state stays IDLE, LEDs 1000.
- **Single trip:** enable, pulse call 1000 → `motor_up` for 12 cycles; `floor` goes 1, 2, 3 at 4-cycle intervals; then `door_open` for 3 cycles; `pending` = 0000; back to IDLE.
- **Collective stop:** from floor 0, calls 1000 and 0010 → car stops at floor 1 (door 3 cycles), then continues to 3. `pending` bit 1 clears on arrival at floor 1.
- **Direction preference:** at floor 2 with `dir_last` = down, calls 1000 and 0001 → DOWN is chosen first.
- **Lock drop mid-trip:** `enable_mc` falls 2 cycles into the 0→2 trip → car reaches floor 1, then IDLE with no door opening; `pending` = 0000.
- **Reset mid-motion:** `Reset` = 0 during UP → all outputs return to their reset values asynchronously, `floor` = 0.

Source files
------------

// File: rtl/montacarga_ctrl_pkg.sv
// Shared definitions for the freight-elevator controller: state encodings,
// state LED patterns and call-search helpers.
package montacarga_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  localparam logic [3:0] LED_IDLE = 4'b1000;
  localparam logic [3:0] LED_UP   = 4'b0100;
  localparam logic [3:0] LED_DOWN = 4'b0010;
  localparam logic [3:0] LED_DOOR = 4'b0001;

  localparam int DEF_N_FLOORS = 4;
  localparam int MAX_FLOORS   = 32;

  // Call vectors are zero-extended to MAX_FLOORS so one helper serves any floor count.
  function automatic logic calls_above(input logic [MAX_FLOORS-1:0] calls, input int idx);
    calls_above = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i > idx && calls[i]) calls_above = 1'b1;
    end
  endfunction

  function automatic logic calls_below(input logic [MAX_FLOORS-1:0] calls, input int idx);
    calls_below = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i < idx && calls[i]) calls_below = 1'b1;
    end
  endfunction

  function automatic logic [3:0] led_pattern(input state_t s);
    case (s)
      ST_UP:   led_pattern = LED_UP;
      ST_DOWN: led_pattern = LED_DOWN;
      ST_DOOR: led_pattern = LED_DOOR;
      default: led_pattern = LED_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/montacarga_ctrl_if.sv
// Lock/call inputs and car status outputs of the elevator controller.
interface montacarga_ctrl_if
  import montacarga_ctrl_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS,
  parameter int FLOOR_W  = 2
);
  logic                enable_mc;
  logic [N_FLOORS-1:0] call_btn;
  logic                motor_up;
  logic                motor_down;
  logic                door_open;
  logic [FLOOR_W-1:0]  floor;
  logic [N_FLOORS-1:0] pending;
  logic [3:0]          out_led_states;

  modport master (
    output enable_mc, call_btn,
    input  motor_up, motor_down, door_open, floor, pending, out_led_states
  );

  modport slave (
    input  enable_mc, call_btn,
    output motor_up, motor_down, door_open, floor, pending, out_led_states
  );
endinterface

// File: rtl/montacarga_ctrl_timer_carga.sv
// Loadable down-counter shared by travel and door timing; done is high in
// the last cycle of a loaded interval.
module timer_carga #(
  parameter int CNT_W = 27
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));
endmodule

// File: rtl/montacarga_ctrl.sv
// Freight-elevator motion controller: latches calls while unlocked, moves one
// floor per travel interval and opens the door at requested floors.
module montacarga_ctrl
  import montacarga_ctrl_pkg::*;
#(
  parameter int N_FLOORS      = DEF_N_FLOORS,
  parameter int FLOOR_W       = 2,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000,
  parameter int CNT_W         = 27
) (
  input logic Clock,
  input logic Reset,
  montacarga_ctrl_if.slave bus
);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES);

  state_t              state, state_next;
  logic [FLOOR_W-1:0]  floor, floor_next, floor_arrive;
  logic                dir_last, dir_next;
  logic [N_FLOORS-1:0] pending, pending_next;
  logic                timer_load, timer_done;
  logic [CNT_W-1:0]    timer_val;
  logic                clr_en;
  logic [FLOOR_W-1:0]  clr_idx;
  logic                calls_up, calls_down, more_up, more_down;

  timer_carga #(.CNT_W(CNT_W)) u_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Call searches relative to the car now and to the floor it is about to reach.
  always_comb begin
    floor_arrive = (state == ST_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    calls_up     = calls_above(MAX_FLOORS'(pending), int'(floor));
    calls_down   = calls_below(MAX_FLOORS'(pending), int'(floor));
    more_up      = calls_above(MAX_FLOORS'(pending), int'(floor_arrive));
    more_down    = calls_below(MAX_FLOORS'(pending), int'(floor_arrive));
  end

  always_comb begin
    state_next = state;
    floor_next = floor;
    dir_next   = dir_last;
    timer_load = 1'b0;
    timer_val  = TRAVEL_LOAD;
    clr_en     = 1'b0;
    clr_idx    = floor;
    case (state)
      ST_IDLE: begin
        if (pending[floor]) begin
          state_next = ST_DOOR;
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
          clr_en     = 1'b1;
        end else if (calls_up && calls_down) begin
          state_next = dir_last ? ST_UP : ST_DOWN;
          timer_load = 1'b1;
        end else if (calls_up) begin
          state_next = ST_UP;
          timer_load = 1'b1;
        end else if (calls_down) begin
          state_next = ST_DOWN;
          timer_load = 1'b1;
        end
      end
      ST_UP, ST_DOWN: begin
        // A move that would leave the shaft is abandoned rather than wrapped.
        if ((state == ST_UP && floor == TOP_FLOOR) || (state == ST_DOWN && floor == '0)) begin
          state_next = ST_IDLE;
        end else if (timer_done) begin
          floor_next = floor_arrive;
          dir_next   = (state == ST_UP);
          if (pending[floor_arrive]) begin
            state_next = ST_DOOR;
            timer_load = 1'b1;
            timer_val  = DOOR_LOAD;
            clr_en     = 1'b1;
            clr_idx    = floor_arrive;
          end else if ((state == ST_UP) ? more_up : more_down) begin
            timer_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (bus.enable_mc && bus.call_btn[floor]) begin
          timer_load = 1'b1;
          timer_val  = DOOR_LOAD;
        end else if (timer_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Serving a floor clears its request even if its button is held that cycle.
  always_comb begin
    pending_next = pending;
    if (bus.enable_mc) begin
      for (int i = 0; i < N_FLOORS; i++) begin
        if (bus.call_btn[i] && !(state == ST_DOOR && FLOOR_W'(i) == floor)) begin
          pending_next[i] = 1'b1;
        end
      end
      if (clr_en) pending_next[clr_idx] = 1'b0;
    end else begin
      pending_next = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      floor    <= '0;
      dir_last <= 1'b1;
      pending  <= '0;
    end else begin
      state    <= state_next;
      floor    <= floor_next;
      dir_last <= dir_next;
      pending  <= pending_next;
    end
  end

  assign bus.motor_up       = (state == ST_UP);
  assign bus.motor_down     = (state == ST_DOWN);
  assign bus.door_open      = (state == ST_DOOR);
  assign bus.floor          = floor;
  assign bus.pending        = pending;
  assign bus.out_led_states = led_pattern(state);
endmodule

// File: tb/tb_montacarga_ctrl.sv
// Scoreboard bench for montacarga_ctrl: a behavioural car model predicts the
// outputs after every edge, and a monitor compares them one cycle later.
module tb_montacarga_ctrl;
  localparam int NF    = 4;
  localparam int TRAV  = 4;
  localparam int DOORC = 3;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  typedef struct packed {
    logic       mu;
    logic       md;
    logic       dopen;
    logic [1:0] fl;
    logic [3:0] pend;
    logic [3:0] leds;
  } view_t;

  logic Clock;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  view_t exp_q[$];

  int      m_mode;
  int      m_floor;
  int      m_left;
  bit      m_dir_up;
  bit [3:0] m_pend;

  montacarga_ctrl_if #(.N_FLOORS(NF), .FLOOR_W(2)) bus ();

  montacarga_ctrl #(
    .N_FLOORS(NF), .FLOOR_W(2), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOORC), .CNT_W(27)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic bit req_above(int f);
    req_above = 1'b0;
    for (int i = f + 1; i < NF; i++) if (m_pend[i]) req_above = 1'b1;
  endfunction

  function automatic bit req_below(int f);
    req_below = 1'b0;
    for (int i = 0; i < f; i++) if (m_pend[i]) req_below = 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_left = 0; m_dir_up = 1'b1; m_pend = '0;
  endtask

  // One clock of the elevator as described by its rules, using last cycle's requests.
  task automatic model_step(input bit en, input bit [3:0] btn);
    int old_mode  = m_mode;
    int old_floor = m_floor;
    int served    = -1;
    bit [3:0] np;
    case (m_mode)
      M_IDLE: begin
        if (m_pend[m_floor]) begin
          m_mode = M_DOOR; m_left = DOORC; served = m_floor;
        end else begin
          bit up = req_above(m_floor);
          bit dn = req_below(m_floor);
          if (up && dn) m_mode = m_dir_up ? M_UP : M_DOWN;
          else if (up)  m_mode = M_UP;
          else if (dn)  m_mode = M_DOWN;
          if (m_mode != M_IDLE) m_left = TRAV;
        end
      end
      M_UP, M_DOWN: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_floor  = m_floor + ((old_mode == M_UP) ? 1 : -1);
          m_dir_up = (old_mode == M_UP);
          if (m_pend[m_floor]) begin
            m_mode = M_DOOR; m_left = DOORC; served = m_floor;
          end else if (m_dir_up ? req_above(m_floor) : req_below(m_floor)) begin
            m_left = TRAV;
          end else begin
            m_mode = M_IDLE;
          end
        end
      end
      default: begin
        if (en && btn[m_floor]) begin
          m_left = DOORC;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    np = m_pend;
    for (int i = 0; i < NF; i++) begin
      if (en && btn[i] && !(old_mode == M_DOOR && i == old_floor)) np[i] = 1'b1;
    end
    if (served >= 0) np[served] = 1'b0;
    if (!en) np = '0;
    m_pend = np;
  endtask

  function automatic view_t model_view();
    view_t v;
    v.mu    = (m_mode == M_UP);
    v.md    = (m_mode == M_DOWN);
    v.dopen = (m_mode == M_DOOR);
    v.fl    = 2'(m_floor);
    v.pend  = m_pend;
    v.leds  = 4'b1000 >> m_mode;
    return v;
  endfunction

  function automatic view_t dut_view();
    view_t v;
    v.mu    = bus.motor_up;
    v.md    = bus.motor_down;
    v.dopen = bus.door_open;
    v.fl    = bus.floor;
    v.pend  = bus.pending;
    v.leds  = bus.out_led_states;
    return v;
  endfunction

  task automatic checkOutput(input string name, input view_t act, input view_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got mu/md/door/floor/pend/leds=%b/%b/%b/%0d/%b/%b want=%b/%b/%b/%0d/%b/%b",
               name, $time, act.mu, act.md, act.dopen, act.fl, act.pend, act.leds,
               exp.mu, exp.md, exp.dopen, exp.fl, exp.pend, exp.leds);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic applyStimulus(input bit rstn, input bit en, input bit [3:0] btn);
    @(negedge Clock);
    Reset         = rstn;
    bus.enable_mc = en;
    bus.call_btn  = btn;
    if (!rstn) model_reset();
    else       model_step(en, btn);
    exp_q.push_back(model_view());
  endtask

  task automatic runUntilMode(input int mode, input int budget, input string name);
    int n = 0;
    while (m_mode != mode && n < budget) begin
      applyStimulus(1'b1, 1'b1, 4'b0000);
      n++;
    end
    total++;
    if (m_mode != mode) begin
      bad++;
      $display("[TB] FAIL %s timeout got mode=%0d want=%0d", name, m_mode, mode);
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (!(m_mode == M_IDLE && m_pend == 4'b0000) && n < budget) begin
      applyStimulus(1'b1, 1'b1, 4'b0000);
      n++;
    end
    total++;
    if (!(m_mode == M_IDLE && m_pend == 4'b0000)) begin
      bad++;
      $display("[TB] FAIL %s timeout got mode=%0d pend=%b want idle/0000", name, m_mode, m_pend);
    end
  endtask

  // Monitor: compares every queued prediction shortly after the edge it refers to.
  initial begin
    view_t a;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        a = dut_view();
        checkOutput("cycle", a, exp_q.pop_front());
        total++;
        if ((a.mu && a.md) || ((a.mu || a.md) && a.dopen)) begin
          bad++;
          $display("[TB] FAIL exclusive_outputs t=%0t got mu/md/door=%b/%b/%b want at most one", $time, a.mu, a.md, a.dopen);
        end
      end
    end
  end

  initial begin
    bit       en;
    bit [3:0] btn;
    view_t    rst_view;
    Reset         = 1'b1;
    bus.enable_mc = 1'b0;
    bus.call_btn  = '0;
    model_reset();
    rst_view = model_view();
    #1 Reset = 1'b0;
    #1 checkOutput("reset_state", dut_view(), rst_view);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);

    $display("[TB] locked call");
    applyStimulus(1'b1, 1'b0, 4'b0100);
    repeat (3) applyStimulus(1'b1, 1'b0, 4'b0000);

    $display("[TB] single trip");
    applyStimulus(1'b1, 1'b1, 4'b1000);
    waitIdle(60, "single_trip");

    $display("[TB] collective stop");
    applyStimulus(1'b1, 1'b1, 4'b0001);
    waitIdle(60, "return_to_0");
    applyStimulus(1'b1, 1'b1, 4'b1010);
    waitIdle(80, "collective");

    $display("[TB] direction preference");
    applyStimulus(1'b1, 1'b1, 4'b0100);
    waitIdle(60, "down_to_2");
    applyStimulus(1'b1, 1'b1, 4'b1001);
    waitIdle(100, "dir_pref");

    $display("[TB] lock drop mid trip");
    applyStimulus(1'b1, 1'b1, 4'b0001);
    waitIdle(60, "return_to_0b");
    applyStimulus(1'b1, 1'b1, 4'b0100);
    repeat (3) applyStimulus(1'b1, 1'b1, 4'b0000);
    repeat (12) applyStimulus(1'b1, 1'b0, 4'b0000);

    $display("[TB] door reload and lock drop in door");
    applyStimulus(1'b1, 1'b1, 4'b1000);
    runUntilMode(M_DOOR, 60, "reach_door_3");
    applyStimulus(1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b1000);
    waitIdle(30, "door_reload");
    applyStimulus(1'b1, 1'b1, 4'b0001);
    runUntilMode(M_DOOR, 60, "reach_door_0");
    repeat (6) applyStimulus(1'b1, 1'b0, 4'b0000);

    $display("[TB] random traffic");
    repeat (400) begin
      en  = ($urandom % 8) != 0;
      btn = (($urandom % 3) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus(1'b1, en, btn);
    end

    $display("[TB] reset during motion");
    waitIdle(200, "settle");
    applyStimulus(1'b1, 1'b1, 4'b0001);
    waitIdle(60, "return_to_0c");
    applyStimulus(1'b1, 1'b1, 4'b1000);
    runUntilMode(M_UP, 10, "depart_up");
    repeat (5) applyStimulus(1'b1, 1'b1, 4'b0000);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1 checkOutput("async_reset", dut_view(), rst_view);
    model_reset();
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    repeat (100) begin
      en  = ($urandom % 6) != 0;
      btn = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus(1'b1, en, btn);
    end

    @(posedge Clock);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d want=0 pending predictions", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
